data_ram_lsu: RTL

//   Load/store initiator for the single-cycle RISC-V data RAM (word-wide, async read, write on clk&&tick).

---
 rtl/data_ram_lsu.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/data_ram_lsu.sv
// Load/store initiator for a word-wide async-read data RAM: B/H/W loads with extension, RMW for SB/SH.
// Optional macro MISALIGN_TRAP_EN: misaligned H/W accesses complete immediately with resp_err.
module data_ram_lsu #(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_d,
    output logic              ram_we,
    input  logic [31:0]       ram_q
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [2:0]          f3_q, f3_d;
    logic [1:0]          off_q, off_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         merge_q, merge_d;
    logic [31:0]         rdata_q, rdata_d;

    logic [31:0]         rel;
    logic [31:ADDR_W+2]  unused_rel_hi;
    logic                req_is_b, req_is_h, req_is_w;
    logic [1:0]          req_off;
    logic [7:0]          lane_b;
    logic [15:0]         lane_h;
    logic [31:0]         merged;

    assign rel           = req_addr - BASE_ADDR;
    assign unused_rel_hi = rel[31:ADDR_W+2];

    // Size comes from funct3[1:0] only; anything that is not B or H behaves as W.
    assign req_is_b = (req_funct3[1:0] == 2'b00);
    assign req_is_h = (req_funct3[1:0] == 2'b01);
    assign req_is_w = !req_is_b && !req_is_h;
    assign req_off  = req_is_b ? rel[1:0] : (req_is_h ? {rel[1], 1'b0} : 2'b00);

    assign lane_b = ram_q[{off_q, 3'b000} +: 8];
    assign lane_h = ram_q[{off_q[1], 4'b0000} +: 16];

`ifdef MISALIGN_TRAP_EN
    logic err_q, err_d;
    logic req_mis;
    assign req_mis  = (req_is_h && rel[0]) || (req_is_w && (rel[1:0] != 2'b00));
    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    always_comb begin
        merged = merge_q;
        if (f3_q[1:0] == 2'b00) begin
            merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        end else if (f3_q[1:0] == 2'b01) begin
            merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    assign ram_d      = (f3_q[1] == 1'b0) ? merged : wdata_q;
    assign ram_addr   = addr_q;
    assign ram_we     = (state_q == S_WRITE) && rst_n;
    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_DONE);
    assign resp_rdata = rdata_q;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
`ifdef MISALIGN_TRAP_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    off_d   = req_off;
                    wdata_d = req_wdata;
                    addr_d  = rel[ADDR_W+1:2];
                    rdata_d = '0;
                    state_d = (req_we && req_is_w) ? S_WRITE : S_READ;
`ifdef MISALIGN_TRAP_EN
                    err_d = req_mis;
                    if (req_mis) begin
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_READ: begin
                merge_d = ram_q;
                if (we_q) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_DONE;
                    case (f3_q)
                        3'b000:  rdata_d = {{24{lane_b[7]}}, lane_b};
                        3'b100:  rdata_d = {24'h0, lane_b};
                        3'b001:  rdata_d = {{16{lane_h[15]}}, lane_h};
                        3'b101:  rdata_d = {16'h0, lane_h};
                        default: rdata_d = ram_q;
                    endcase
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            merge_q <= '0;
            rdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else if (tick) begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
`ifdef MISALIGN_TRAP_EN
            err_q   <= err_d;
`endif
        end
    end

endmodule
